uart_cmd_rx: RTL and testbench

Receives 8N1 asynchronous serial bytes from the host control line and presents each good byte as a single-cycle command strobe plus data byte. Sits directly upstream of the command decoder: `latchCommand`/`command` connect straight to the decoder's inputs of the same names. It runs in the decoder's `clk` domain. Framing errors are flagged and never forwarded.

---
 rtl/uart_cmd_rx_if.sv | 34 +++
 rtl/uart_cmd_rx.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rx_if.sv
// ============================================================================
// Module : uart_cmd_rx_if
// Brief  : Serial input and command-strobe outputs of the UART command receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_cmd_rx_if;
   logic       rxd;
   logic       latchCommand;
   logic [7:0] command;
   logic       frameError;
   logic       rxBusy;

   // Receiver side: consumes the serial line, sources the command stream.
   modport master (
      input  rxd,
      output latchCommand,
      output command,
      output frameError,
      output rxBusy
   );

   // Host/decoder side: drives the serial line, consumes the command stream.
   modport slave (
      output rxd,
      input  latchCommand,
      input  command,
      input  frameError,
      input  rxBusy
   );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_rx.sv
// ============================================================================
// Module : uart_cmd_rx
// Brief  : 8N1 serial receiver that presents good bytes as a one-cycle command
//          strobe; bad stop bits raise frameError and wait out any break.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_rx #(
   parameter int CLKS_PER_BIT = 417
) (
   input  wire logic      clk,
   input  wire logic      rst,
   uart_cmd_rx_if.master  bus
);

   localparam logic [15:0] c_FULL_M1 = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] c_HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic        r_sync1;
   logic        r_sync2;
   logic        w_rxs;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_idx;
   logic [7:0]  r_shift;
   logic [7:0]  r_command;
   logic        r_latch;
   logic        r_ferr;
   logic        r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.rxd;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_idx     <= 3'd0;
         r_shift   <= 8'h00;
         r_command <= 8'h00;
         r_latch   <= 1'b0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_latch <= 1'b0;
         r_ferr  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rxs) begin
                  r_cnt   <= 16'd0;
                  r_state <= S_START;
                  r_busy  <= 1'b1;
               end
            end

            S_START: begin
               if (r_cnt == c_HALF_M1) begin
                  r_cnt <= 16'd0;
                  if (!w_rxs) begin
                     r_idx   <= 3'd0;
                     r_state <= S_DATA;
                  end else begin
                     // Line bounced back high before mid-start: treat as noise.
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end

            S_DATA: begin
               if (r_cnt == c_FULL_M1) begin
                  r_cnt          <= 16'd0;
                  r_shift[r_idx] <= w_rxs;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end

            S_STOP: begin
               if (r_cnt == c_FULL_M1) begin
                  r_cnt <= 16'd0;
                  if (w_rxs) begin
                     r_command <= r_shift;
                     r_latch   <= 1'b1;
                     r_state   <= S_IDLE;
                     r_busy    <= 1'b0;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end

            // A held-low line must not decode as a stream of 0x00 frames.
            S_BREAK: begin
               if (w_rxs) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.latchCommand = r_latch;
   assign bus.command      = r_command;
   assign bus.frameError   = r_ferr;
   assign bus.rxBusy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
// Directed-vector bench for uart_cmd_rx at CLKS_PER_BIT=16 with a scoreboard
// monitor that pairs every output strobe with a queued expectation.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cmd_rx;

   localparam int N  = 16;
   localparam int BT = 160;   // one bit time in ns at a 10 ns clock

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         exp_cyc;    // -1 when arrival cycle is not checked
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   ntests = 0;
   int   nfail  = 0;
   exp_t q[$];

   uart_cmd_rx_if bus ();

   uart_cmd_rx #(.CLKS_PER_BIT(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every strobe must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.latchCommand && bus.frameError) begin
            check("strobe_exclusive", 32'd1, 32'd0);
         end
         if (bus.latchCommand || bus.frameError) begin
            if (q.size() == 0) begin
               check("unexpected_strobe", {bus.frameError, bus.latchCommand}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("strobe_kind", {31'd0, bus.frameError}, {31'd0, e.is_err});
               if (!e.is_err) check("command_value", bus.command, e.data);
               if (e.exp_cyc >= 0) check("strobe_cycle", cyc, e.exp_cyc);
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input bit stop, input int bt);
      bus.rxd = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         bus.rxd = d[i];
         #(bt);
      end
      bus.rxd = stop;
      #(bt);
   endtask

   task automatic align(output int k);
      @(negedge clk);
      #1;
      k = cyc;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic push(input bit is_err, input logic [7:0] d, input int c);
      exp_t e;
      e.is_err  = is_err;
      e.data    = d;
      e.exp_cyc = c;
      q.push_back(e);
   endtask

   initial begin
      int k;
      bus.rxd = 1'b1;
      rst     = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_latch",   {31'd0, bus.latchCommand}, 32'd0);
      check("reset_ferr",    {31'd0, bus.frameError},   32'd0);
      check("reset_command", bus.command,               32'h00);
      check("reset_busy",    {31'd0, bus.rxBusy},       32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single byte: strobe in the cycle after edge T0+H+9N, T0 = k+3.
      align(k);
      push(1'b0, 8'h32, k + 3 + 8 + 144);
      send_frame(8'h32, 1'b1, BT);
      #(2 * BT);

      // Back-to-back with no idle gap.
      align(k);
      push(1'b0, 8'h31, k + 155);
      push(1'b0, 8'h34, k + 160 + 155);
      send_frame(8'h31, 1'b1, BT);
      send_frame(8'h34, 1'b1, BT);
      #(2 * BT);
      check("b2b_hold", bus.command, 32'h34);

      // Glitch: 3 low cycles, T0 = k+3, start check at T0+8.
      align(k);
      bus.rxd = 1'b0;
      #30;
      bus.rxd = 1'b1;
      wait_cyc(k + 4);
      check("glitch_busy_high", {31'd0, bus.rxBusy}, 32'd1);
      wait_cyc(k + 12);
      check("glitch_busy_low", {31'd0, bus.rxBusy}, 32'd0);
      check("glitch_hold", bus.command, 32'h34);
      #(BT);
      push(1'b0, 8'hA5, -1);
      send_frame(8'hA5, 1'b1, BT);
      #(2 * BT);

      // Framing error followed by a 40-bit break.
      align(k);
      push(1'b1, 8'h00, k + 155);
      send_frame(8'h34, 1'b0, BT);
      #(20 * BT);
      check("break_busy", {31'd0, bus.rxBusy}, 32'd1);
      #(20 * BT);
      bus.rxd = 1'b1;
      repeat (5) @(negedge clk);
      check("break_exit_busy", {31'd0, bus.rxBusy}, 32'd0);
      check("ferr_cmd_kept", bus.command, 32'hA5);
      #(BT);
      push(1'b0, 8'h31, -1);
      send_frame(8'h31, 1'b1, BT);
      #(2 * BT);

      // Reset after data bit 3 of 0x5A; host abandons the frame.
      align(k);
      bus.rxd = 1'b0;
      #(BT);
      for (int i = 0; i < 4; i++) begin
         bus.rxd = (8'h5A >> i) & 8'h01;
         #(BT);
      end
      bus.rxd = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_cmd_cleared", bus.command, 32'h00);
      check("rst_busy", {31'd0, bus.rxBusy}, 32'd0);
      #(3 * BT);
      align(k);
      push(1'b0, 8'h32, k + 155);
      send_frame(8'h32, 1'b1, BT);
      #(2 * BT);

      // Baud skew: 16.5, 15.5, 16.5 clocks per bit, back-to-back.
      align(k);
      push(1'b0, 8'h00, -1);
      push(1'b0, 8'hFF, -1);
      push(1'b0, 8'h55, -1);
      send_frame(8'h00, 1'b1, BT + 5);
      send_frame(8'hFF, 1'b1, BT - 5);
      send_frame(8'h55, 1'b1, BT + 5);
      #(3 * BT);
      check("skew_final_cmd", bus.command, 32'h55);
      check("queue_drained", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule

`default_nettype wire
